// File: rtl/rob.sv
// Reorder buffer: 32 entries, two-wide dispatch, completion and in-order retire; all outputs zero latency.
// Backpressure: dispatch is refused via rob_instA_en_out/rob_instB_en_out when free entries run out.
module rob (
  input  logic       clock,
  input  logic       reset,
  input  logic       id_valid_instA,
  input  logic       id_valid_instB,
  input  logic [5:0] mt_ToldA,
  input  logic [5:0] mt_ToldB,
  input  logic [5:0] fl_TA,
  input  logic [5:0] fl_TB,
  input  logic [4:0] id_logdestAIdx,
  input  logic [4:0] id_logdestBIdx,
  input  logic       ex_cm_cdbA_rdy,
  input  logic       ex_cm_cdbB_rdy,
  input  logic [4:0] ex_cm_robAIdx,
  input  logic [4:0] ex_cm_robBIdx,
  output logic       rob_instA_en_out,
  output logic       rob_instB_en_out,
  output logic [4:0] rob_dispidxA_out,
  output logic [4:0] rob_dispidxB_out,
  output logic       rob_retireA_out,
  output logic       rob_retireB_out,
  output logic [5:0] rob_TA_out,
  output logic [5:0] rob_TB_out,
  output logic [5:0] rob_ToldA_out,
  output logic [5:0] rob_ToldB_out,
  output logic [4:0] rob_logidxA_out,
  output logic [4:0] rob_logidxB_out,
  output logic       rob_one_inst_out,
  output logic       rob_none_inst_out
);

  logic [5:0]  T          [32];
  logic [5:0]  T_old      [32];
  logic [4:0]  logdestIdx [32];
  logic [31:0] done;
  logic [4:0]  head;
  logic [4:0]  tail;
  logic [5:0]  count;

  logic [5:0]  freeCnt;
  logic [4:0]  headNext1;
  logic        instAEn;
  logic        instBEn;
  logic [4:0]  dispIdxA;
  logic [4:0]  dispIdxB;
  logic        retireA;
  logic        retireB;
  logic [5:0]  dispCnt;
  logic [5:0]  retCnt;
  logic [31:0] doneNext;

  // Free space uses the registered count, so slots retiring this cycle are not reused yet.
  assign freeCnt   = 6'd32 - count;
  assign headNext1 = head + 5'd1;

  always_comb begin
    instAEn  = id_valid_instA && (freeCnt >= 6'd1);
    instBEn  = id_valid_instB && (freeCnt >= (instAEn ? 6'd2 : 6'd1));
    dispIdxA = tail;
    dispIdxB = tail + {4'd0, instAEn};
    retireA  = (count >= 6'd1) && done[head];
    retireB  = retireA && (count >= 6'd2) && done[headNext1];
    dispCnt  = 6'(instAEn) + 6'(instBEn);
    retCnt   = 6'(retireA) + 6'(retireB);
  end

  assign rob_instA_en_out  = instAEn;
  assign rob_instB_en_out  = instBEn;
  assign rob_dispidxA_out  = dispIdxA;
  assign rob_dispidxB_out  = dispIdxB;
  assign rob_retireA_out   = retireA;
  assign rob_retireB_out   = retireB;
  assign rob_TA_out        = retireA ? T[head]               : 6'd0;
  assign rob_ToldA_out     = retireA ? T_old[head]           : 6'd0;
  assign rob_logidxA_out   = retireA ? logdestIdx[head]      : 5'd0;
  assign rob_TB_out        = retireB ? T[headNext1]          : 6'd0;
  assign rob_ToldB_out     = retireB ? T_old[headNext1]      : 6'd0;
  assign rob_logidxB_out   = retireB ? logdestIdx[headNext1] : 5'd0;
  assign rob_one_inst_out  = (count == 6'd31);
  assign rob_none_inst_out = (count == 6'd32);

  // Later assignments take priority: a dispatch into a slot beats a completion to it.
  always_comb begin
    doneNext = done;
    if (ex_cm_cdbA_rdy) doneNext[ex_cm_robAIdx] = 1'b1;
    if (ex_cm_cdbB_rdy) doneNext[ex_cm_robBIdx] = 1'b1;
    if (retireA)        doneNext[head]          = 1'b0;
    if (retireB)        doneNext[headNext1]     = 1'b0;
    if (instAEn)        doneNext[dispIdxA]      = 1'b0;
    if (instBEn)        doneNext[dispIdxB]      = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= 5'd0;
      tail  <= 5'd0;
      count <= 6'd0;
      done  <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        T[i]          <= 6'd0;
        T_old[i]      <= 6'd0;
        logdestIdx[i] <= 5'd0;
      end
    end else begin
      head  <= head + retCnt[4:0];
      tail  <= tail + dispCnt[4:0];
      count <= count + dispCnt - retCnt;
      done  <= doneNext;
      if (instAEn) begin
        T[dispIdxA]          <= fl_TA;
        T_old[dispIdxA]      <= mt_ToldA;
        logdestIdx[dispIdxA] <= id_logdestAIdx;
      end
      if (instBEn) begin
        T[dispIdxB]          <= fl_TB;
        T_old[dispIdxB]      <= mt_ToldB;
        logdestIdx[dispIdxB] <= id_logdestBIdx;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: queue-based reference model, retire scoreboard with an independent monitor.
module tb_rob;
  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid_instA, id_valid_instB;
  logic [5:0] mt_ToldA, mt_ToldB, fl_TA, fl_TB;
  logic [4:0] id_logdestAIdx, id_logdestBIdx;
  logic       ex_cm_cdbA_rdy, ex_cm_cdbB_rdy;
  logic [4:0] ex_cm_robAIdx, ex_cm_robBIdx;
  logic       rob_instA_en_out, rob_instB_en_out;
  logic [4:0] rob_dispidxA_out, rob_dispidxB_out;
  logic       rob_retireA_out, rob_retireB_out;
  logic [5:0] rob_TA_out, rob_TB_out, rob_ToldA_out, rob_ToldB_out;
  logic [4:0] rob_logidxA_out, rob_logidxB_out;
  logic       rob_one_inst_out, rob_none_inst_out;

  rob dut (
    .clock(clock), .reset(reset),
    .id_valid_instA(id_valid_instA), .id_valid_instB(id_valid_instB),
    .mt_ToldA(mt_ToldA), .mt_ToldB(mt_ToldB), .fl_TA(fl_TA), .fl_TB(fl_TB),
    .id_logdestAIdx(id_logdestAIdx), .id_logdestBIdx(id_logdestBIdx),
    .ex_cm_cdbA_rdy(ex_cm_cdbA_rdy), .ex_cm_cdbB_rdy(ex_cm_cdbB_rdy),
    .ex_cm_robAIdx(ex_cm_robAIdx), .ex_cm_robBIdx(ex_cm_robBIdx),
    .rob_instA_en_out(rob_instA_en_out), .rob_instB_en_out(rob_instB_en_out),
    .rob_dispidxA_out(rob_dispidxA_out), .rob_dispidxB_out(rob_dispidxB_out),
    .rob_retireA_out(rob_retireA_out), .rob_retireB_out(rob_retireB_out),
    .rob_TA_out(rob_TA_out), .rob_TB_out(rob_TB_out),
    .rob_ToldA_out(rob_ToldA_out), .rob_ToldB_out(rob_ToldB_out),
    .rob_logidxA_out(rob_logidxA_out), .rob_logidxB_out(rob_logidxB_out),
    .rob_one_inst_out(rob_one_inst_out), .rob_none_inst_out(rob_none_inst_out)
  );

  always #5 clock = ~clock;

  typedef struct { int idx; int t; int told; int ld; } ent_t;
  typedef struct { int t; int told; int ld; } ret_t;

  ent_t rq[$];      // in-flight instructions, oldest first
  ret_t expQ[$];    // expected retire stream
  bit   mdone[32];
  int   mtail;
  int   nChecks = 0;
  int   nFail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    rq.delete();
    expQ.delete();
    foreach (mdone[i]) mdone[i] = 1'b0;
    mtail = 0;
  endtask

  task automatic idleInputs();
    id_valid_instA = 0; id_valid_instB = 0;
    mt_ToldA = 0; mt_ToldB = 0; fl_TA = 0; fl_TB = 0;
    id_logdestAIdx = 0; id_logdestBIdx = 0;
    ex_cm_cdbA_rdy = 0; ex_cm_cdbB_rdy = 0;
    ex_cm_robAIdx = 0; ex_cm_robBIdx = 0;
  endtask

  // Pulses reset away from the clock edge and checks the cleared, empty-ROB outputs.
  task automatic doReset();
    idleInputs();
    id_valid_instA = 1; id_valid_instB = 1;
    reset = 1;
    #1;
    chk("rst instA_en", 32'(rob_instA_en_out), 1);
    chk("rst instB_en", 32'(rob_instB_en_out), 1);
    chk("rst dispidxA", 32'(rob_dispidxA_out), 0);
    chk("rst dispidxB", 32'(rob_dispidxB_out), 1);
    chk("rst retireA", 32'(rob_retireA_out), 0);
    chk("rst retireB", 32'(rob_retireB_out), 0);
    chk("rst TA", 32'(rob_TA_out), 0);
    chk("rst one", 32'(rob_one_inst_out), 0);
    chk("rst none", 32'(rob_none_inst_out), 0);
    idleInputs();
    clearModel();
    reset = 0;
    @(posedge clock); #1;
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input int vA, input int vB, input int tA, input int tB,
                       input int oA, input int oB, input int lA, input int lB,
                       input int cA, input int cB, input int iA, input int iB);
    int sz, fr, eA, eB, dA, dB, rA, rB;
    ent_t e;
    ret_t r;
    id_valid_instA = (vA != 0); id_valid_instB = (vB != 0);
    fl_TA = 6'(tA); fl_TB = 6'(tB); mt_ToldA = 6'(oA); mt_ToldB = 6'(oB);
    id_logdestAIdx = 5'(lA); id_logdestBIdx = 5'(lB);
    ex_cm_cdbA_rdy = (cA != 0); ex_cm_cdbB_rdy = (cB != 0);
    ex_cm_robAIdx = 5'(iA); ex_cm_robBIdx = 5'(iB);
    #3;
    sz = rq.size();
    fr = 32 - sz;
    eA = (vA != 0 && fr >= 1) ? 1 : 0;
    eB = (vB != 0 && fr >= (eA != 0 ? 2 : 1)) ? 1 : 0;
    dA = mtail;
    dB = (mtail + eA) % 32;
    rA = 0; rB = 0;
    if (sz >= 1 && mdone[rq[0].idx]) rA = 1;
    if (rA != 0 && sz >= 2 && mdone[rq[1].idx]) rB = 1;
    chk("instA_en", 32'(rob_instA_en_out), eA);
    chk("instB_en", 32'(rob_instB_en_out), eB);
    chk("dispidxA", 32'(rob_dispidxA_out), dA);
    chk("dispidxB", 32'(rob_dispidxB_out), dB);
    chk("retireA", 32'(rob_retireA_out), rA);
    chk("retireB", 32'(rob_retireB_out), rB);
    chk("one_inst", 32'(rob_one_inst_out), (sz == 31) ? 1 : 0);
    chk("none_inst", 32'(rob_none_inst_out), (sz == 32) ? 1 : 0);
    if (cA != 0) mdone[iA] = 1'b1;
    if (cB != 0) mdone[iB] = 1'b1;
    if (rA != 0) begin mdone[rq[0].idx] = 1'b0; void'(rq.pop_front()); end
    if (rB != 0) begin mdone[rq[0].idx] = 1'b0; void'(rq.pop_front()); end
    if (eA != 0) begin
      e.idx = dA; e.t = tA; e.told = oA; e.ld = lA; rq.push_back(e); mdone[dA] = 1'b0;
      r.t = tA; r.told = oA; r.ld = lA; expQ.push_back(r);
    end
    if (eB != 0) begin
      e.idx = dB; e.t = tB; e.told = oB; e.ld = lB; rq.push_back(e); mdone[dB] = 1'b0;
      r.t = tB; r.told = oB; r.ld = lB; expQ.push_back(r);
    end
    mtail = (mtail + eA + eB) % 32;
    @(posedge clock); #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic complete(input int cA, input int cB, input int iA, input int iB);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, cA, cB, iA, iB);
  endtask

  task automatic randCycle(input int rate);
    int sz, iA, iB;
    sz = rq.size();
    iA = (sz > 0 && $urandom_range(0, 3) != 0) ? rq[$urandom_range(0, sz - 1)].idx : int'($urandom_range(0, 31));
    iB = (sz > 0 && $urandom_range(0, 3) != 0) ? rq[$urandom_range(0, sz - 1)].idx : int'($urandom_range(0, 31));
    cycle(($urandom_range(0, 99) < rate) ? 1 : 0, ($urandom_range(0, 99) < rate) ? 1 : 0,
          int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
          int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 2) != 0), int'($urandom_range(0, 2) != 0), iA, iB);
  endtask

  // Monitor: every retire the DUT presents must match the next expected entry in order.
  initial begin
    ret_t r;
    forever begin
      @(negedge clock); #2;
      if (!reset) begin
        if (rob_retireA_out) begin
          if (expQ.size() == 0) begin
            nChecks++; nFail++;
            $display("FAIL retireA unexpected: got retire with empty scoreboard at %0t", $time);
          end else begin
            r = expQ.pop_front();
            chk("mon TA", 32'(rob_TA_out), r.t);
            chk("mon ToldA", 32'(rob_ToldA_out), r.told);
            chk("mon logidxA", 32'(rob_logidxA_out), r.ld);
          end
        end else begin
          chk("mon idle A outs", {20'd0, rob_TA_out, rob_ToldA_out}, 0);
        end
        if (rob_retireB_out) begin
          if (expQ.size() == 0) begin
            nChecks++; nFail++;
            $display("FAIL retireB unexpected: got retire with empty scoreboard at %0t", $time);
          end else begin
            r = expQ.pop_front();
            chk("mon TB", 32'(rob_TB_out), r.t);
            chk("mon ToldB", 32'(rob_ToldB_out), r.told);
            chk("mon logidxB", 32'(rob_logidxB_out), r.ld);
          end
        end else begin
          chk("mon idle B outs", {20'd0, rob_TB_out, rob_ToldB_out}, 0);
        end
      end
    end
  end

  initial begin
    int guard;
    int picked [$];
    idleInputs();
    clearModel();
    doReset();

    // Fill: 16 paired dispatches
    for (int i = 0; i < 16; i++) cycle(1, 1, 32 + 2 * i, 33 + 2 * i, 2 * i, 2 * i + 1, 0, 1, 0, 0, 0, 0);
    chk("full none", 32'(rob_none_inst_out), 1);
    chk("full one", 32'(rob_one_inst_out), 0);
    cycle(1, 0, 62, 0, 5, 0, 3, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 63, 0, 6, 0, 4, 0, 0, 0, 0);

    complete(1, 1, 0, 1);
    chk("ret01 retireA", 32'(rob_retireA_out), 1);
    chk("ret01 retireB", 32'(rob_retireB_out), 1);
    chk("ret01 TA", 32'(rob_TA_out), 32);
    chk("ret01 ToldA", 32'(rob_ToldA_out), 0);
    chk("ret01 logidxA", 32'(rob_logidxA_out), 0);
    chk("ret01 TB", 32'(rob_TB_out), 33);
    chk("ret01 ToldB", 32'(rob_ToldB_out), 1);
    chk("ret01 logidxB", 32'(rob_logidxB_out), 1);
    idle();
    chk("after ret none", 32'(rob_none_inst_out), 0);

    complete(1, 1, 3, 4);
    complete(1, 1, 2, 5);
    chk("ret23 TA", 32'(rob_TA_out), 34);
    chk("ret23 TB", 32'(rob_TB_out), 35);
    idle();
    chk("ret45 TA", 32'(rob_TA_out), 36);
    chk("ret45 TB", 32'(rob_TB_out), 37);
    idle();

    complete(0, 1, 0, 7);
    idle();
    complete(1, 0, 6, 0);
    idle();
    complete(1, 0, 8, 0);
    chk("head only retireA", 32'(rob_retireA_out), 1);
    chk("head only retireB", 32'(rob_retireB_out), 0);
    idle();

    // Near-full boundary and tail wrap
    doReset();
    for (int i = 0; i < 15; i++) cycle(1, 1, i, i + 1, i, i, i, i, 0, 0, 0, 0);
    cycle(1, 0, 40, 0, 41, 0, 7, 0, 0, 0, 0, 0);
    chk("count31 one", 32'(rob_one_inst_out), 1);
    cycle(1, 1, 42, 43, 1, 2, 8, 9, 0, 0, 0, 0);
    chk("count32 none", 32'(rob_none_inst_out), 1);
    complete(1, 1, 0, 1);
    idle();
    cycle(1, 1, 50, 51, 52, 53, 10, 11, 0, 0, 0, 0);
    idle();

    for (int i = 0; i < 1500; i++) randCycle(80);
    for (int i = 0; i < 1000; i++) randCycle(30);
    doReset();
    for (int i = 0; i < 800; i++) randCycle(60);
    for (int i = 0; i < 20; i++) randCycle(90);
    doReset();
    for (int i = 0; i < 500; i++) randCycle(70);

    // Drain: complete everything outstanding
    guard = 0;
    while (rq.size() != 0 && guard < 300) begin
      picked.delete();
      foreach (rq[i]) if (!mdone[rq[i].idx] && picked.size() < 2) picked.push_back(rq[i].idx);
      if (picked.size() == 2) complete(1, 1, picked[0], picked[1]);
      else if (picked.size() == 1) complete(1, 0, picked[0], 0);
      else idle();
      guard++;
    end
    idle();
    idle();
    chk("drain model empty", rq.size(), 0);
    chk("drain scoreboard empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
